// File: rtl/aq_djpeg_pixout_if.sv
// Pixel-output bus of aq_djpeg_pixout: pixel strobe/backpressure from the
// colour converter on one side, show-ahead word handshake to the sink on the other.
interface aq_djpeg_pixout_if;
  logic        InEnable;
  logic [15:0] InPixelX;
  logic [15:0] InPixelY;
  logic [7:0]  InR;
  logic [7:0]  InG;
  logic [7:0]  InB;
  logic        InFull;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [15:0] OutX;
  logic [15:0] OutY;
  logic [1:0]  OutLanes;
  logic        OutLast;

  modport master (
    output InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
    input  InFull, OutValid, OutData, OutX, OutY, OutLanes, OutLast
  );

  modport slave (
    input  InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
    output InFull, OutValid, OutData, OutX, OutY, OutLanes, OutLast
  );
endinterface

// File: rtl/aq_djpeg_pixout.sv
// JPEG decoder pixel output stage: optional RGB565 pair packer feeding a show-ahead FIFO.
// Define AQ_DJPEG_PIXOUT_CLIP_EN to discard MCU padding pixels outside InWidth x InHeight.
module aq_djpeg_pixout #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  parameter int PIX_FMT     = 0,
  parameter int FLUSH_CYC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Init,
  input  logic [15:0]              InWidth,
  input  logic [15:0]              InHeight,
  aq_djpeg_pixout_if.slave         bus,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(FLUSH_CYC + 1);
  localparam int EW = 32 + 16 + 16 + 2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);
  localparam logic [IW-1:0] FLUSH_C = IW'(FLUSH_CYC - 1);

  typedef enum logic {EMPTY, HALF} packState_t;

  function automatic logic [15:0] toRgb565(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  packState_t    state, nextState;
  logic [IW-1:0] idleCnt;
  logic [15:0]   heldPix, heldX, heldY;
  logic          heldLast;
  logic          store;

  logic          inRange, pixIn, isLast;
  logic [15:0]   pix565;

  logic          vld_p0;
  logic [31:0]   data_p0;
  logic [15:0]   x_p0, y_p0;
  logic [1:0]    lanes_p0;
  logic          last_p0;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          pop, pushOk, drop, inFullReg;

`ifdef AQ_DJPEG_PIXOUT_CLIP_EN
  assign inRange = (bus.InPixelX < InWidth) && (bus.InPixelY < InHeight);
`else
  assign inRange = 1'b1;
`endif

  assign pixIn  = bus.InEnable & ~Init & inRange;
  assign isLast = (bus.InPixelX == InWidth - 16'd1) && (bus.InPixelY == InHeight - 16'd1);
  assign pix565 = toRgb565(bus.InR, bus.InG, bus.InB);

  // Stage p0: packer decides what (if anything) is pushed this cycle
  always_comb begin
    nextState = state;
    store     = 1'b0;
    vld_p0    = 1'b0;
    data_p0   = '0;
    x_p0      = bus.InPixelX;
    y_p0      = bus.InPixelY;
    lanes_p0  = 2'b01;
    last_p0   = isLast;
    if (PIX_FMT == 0) begin
      vld_p0  = pixIn;
      data_p0 = {8'h00, bus.InR, bus.InG, bus.InB};
    end else begin
      unique case (state)
        EMPTY: begin
          if (pixIn) begin
            // The frame's final pixel has no partner coming, so it goes out alone
            if (isLast) begin
              vld_p0  = 1'b1;
              data_p0 = {16'h0000, pix565};
            end else begin
              store     = 1'b1;
              nextState = HALF;
            end
          end
        end
        HALF: begin
          x_p0    = heldX;
          y_p0    = heldY;
          last_p0 = heldLast;
          data_p0 = {16'h0000, heldPix};
          if (pixIn) begin
            vld_p0 = 1'b1;
            if (bus.InPixelY == heldY && bus.InPixelX == heldX + 16'd1) begin
              data_p0   = {pix565, heldPix};
              lanes_p0  = 2'b11;
              last_p0   = heldLast | isLast;
              nextState = EMPTY;
            end else begin
              store = 1'b1;
            end
          end else if (idleCnt == FLUSH_C) begin
            vld_p0    = 1'b1;
            nextState = EMPTY;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
    if (Init) vld_p0 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      idleCnt <= '0;
    end else if (Init) begin
      state   <= EMPTY;
      idleCnt <= '0;
    end else begin
      state   <= nextState;
      idleCnt <= (nextState == HALF && !pixIn) ? idleCnt + IW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      heldPix  <= pix565;
      heldX    <= bus.InPixelX;
      heldY    <= bus.InPixelY;
      heldLast <= isLast;
    end
  end

  // Stage p1: FIFO storage; a full FIFO still accepts when the head leaves this cycle
  assign pop    = bus.OutValid & bus.OutReady;
  assign pushOk = vld_p0 & ((Count < DEPTH_C) | pop);
  assign drop   = vld_p0 & ~pushOk;

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= {data_p0, x_p0, y_p0, lanes_p0, last_p0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      inFullReg <= 1'b0;
    end else if (Init) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      inFullReg <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      unique case ({pushOk, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
      if (drop) Overflow <= 1'b1;
      inFullReg <= (Count >= AFULL_C);
    end
  end

  // Head entry is masked while empty so reset and Init show all-zero outputs
  assign bus.InFull   = inFullReg;
  assign bus.OutValid = (Count != '0);
  assign {bus.OutData, bus.OutX, bus.OutY, bus.OutLanes, bus.OutLast} =
      bus.OutValid ? mem[rdPtr] : '0;

endmodule

// File: tb/tb_aq_djpeg_pixout.sv
// Directed bench for aq_djpeg_pixout: one RGB888 instance and one RGB565 packer instance.
module tb_aq_djpeg_pixout;
  logic        clk = 1'b0;
  logic        rst;
  logic        Init;
  logic [15:0] W, H;
  logic        ovf0, ovf1;
  logic [4:0]  cnt0, cnt1;
  int          checks = 0;
  int          errors = 0;

  aq_djpeg_pixout_if bus0();
  aq_djpeg_pixout_if bus1();

  aq_djpeg_pixout #(.DEPTH(16), .AFULL_LEVEL(12), .PIX_FMT(0), .FLUSH_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .Init(Init), .InWidth(W), .InHeight(H),
    .bus(bus0), .Overflow(ovf0), .Count(cnt0));

  aq_djpeg_pixout #(.DEPTH(16), .AFULL_LEVEL(12), .PIX_FMT(1), .FLUSH_CYC(4)) dut1 (
    .clk(clk), .rst(rst), .Init(Init), .InWidth(W), .InHeight(H),
    .bus(bus1), .Overflow(ovf1), .Count(cnt1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus0.InEnable = 1'b1; bus0.InPixelX = x; bus0.InPixelY = y;
    bus0.InR = r; bus0.InG = g; bus0.InB = b;
  endtask

  task automatic drive1(input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus1.InEnable = 1'b1; bus1.InPixelX = x; bus1.InPixelY = y;
    bus1.InR = r; bus1.InG = g; bus1.InB = b;
  endtask

  task automatic test_reset();
    rst = 1'b0; Init = 1'b0; W = 16'd10; H = 16'd8;
    bus0.InEnable = 1'b0; bus0.InPixelX = '0; bus0.InPixelY = '0;
    bus0.InR = '0; bus0.InG = '0; bus0.InB = '0; bus0.OutReady = 1'b0;
    bus1.InEnable = 1'b0; bus1.InPixelX = '0; bus1.InPixelY = '0;
    bus1.InR = '0; bus1.InG = '0; bus1.InB = '0; bus1.OutReady = 1'b0;
    repeat (3) tick();
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_count0: got %0d exp 0", cnt0); end
    checks++; if (bus0.OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b exp 0", bus0.OutValid); end
    checks++; if (bus0.InFull !== 1'b0) begin errors++; $display("FAIL reset_infull0: got %b exp 0", bus0.InFull); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf0: got %b exp 0", ovf0); end
    checks++; if (bus0.OutData !== 32'h0) begin errors++; $display("FAIL reset_data0: got %h exp 0", bus0.OutData); end
    checks++; if (cnt1 !== 5'd0) begin errors++; $display("FAIL reset_count1: got %0d exp 0", cnt1); end
    checks++; if (bus1.OutLanes !== 2'b00) begin errors++; $display("FAIL reset_lanes1: got %b exp 00", bus1.OutLanes); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rgb888();
    bus0.OutReady = 1'b1;
    drive0(16'd3, 16'd5, 8'h12, 8'h34, 8'h56);
    tick();
    bus0.InEnable = 1'b0;
    checks++; if (bus0.OutValid !== 1'b1) begin errors++; $display("FAIL rgb888_valid: got %b exp 1", bus0.OutValid); end
    checks++; if (bus0.OutData !== 32'h00123456) begin errors++; $display("FAIL rgb888_data: got %h exp 00123456", bus0.OutData); end
    checks++; if (bus0.OutX !== 16'd3 || bus0.OutY !== 16'd5) begin errors++; $display("FAIL rgb888_xy: got %0d,%0d exp 3,5", bus0.OutX, bus0.OutY); end
    checks++; if (bus0.OutLanes !== 2'b01) begin errors++; $display("FAIL rgb888_lanes: got %b exp 01", bus0.OutLanes); end
    checks++; if (bus0.OutLast !== 1'b0) begin errors++; $display("FAIL rgb888_last: got %b exp 0", bus0.OutLast); end
    tick();
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL rgb888_popped: got %0d exp 0", cnt0); end
    bus0.OutReady = 1'b0;
  endtask

  task automatic test_pack_pair();
    drive1(16'd0, 16'd0, 8'hFF, 8'hFF, 8'hFF);
    tick();
    checks++; if (cnt1 !== 5'd0) begin errors++; $display("FAIL pair_held: got %0d exp 0", cnt1); end
    drive1(16'd1, 16'd0, 8'h00, 8'h00, 8'h00);
    tick();
    bus1.InEnable = 1'b0;
    checks++; if (cnt1 !== 5'd1) begin errors++; $display("FAIL pair_count: got %0d exp 1", cnt1); end
    checks++; if (bus1.OutData !== 32'h0000FFFF) begin errors++; $display("FAIL pair_data: got %h exp 0000ffff", bus1.OutData); end
    checks++; if (bus1.OutLanes !== 2'b11) begin errors++; $display("FAIL pair_lanes: got %b exp 11", bus1.OutLanes); end
    checks++; if (bus1.OutX !== 16'd0 || bus1.OutLast !== 1'b0) begin errors++; $display("FAIL pair_x_last: got %0d/%b exp 0/0", bus1.OutX, bus1.OutLast); end
    bus1.OutReady = 1'b1;
    tick();
    bus1.OutReady = 1'b0;
    checks++; if (cnt1 !== 5'd0) begin errors++; $display("FAIL pair_pop: got %0d exp 0", cnt1); end
  endtask

  task automatic test_flush();
    drive1(16'd6, 16'd2, 8'h12, 8'h34, 8'h56);
    tick();
    bus1.InEnable = 1'b0;
    repeat (3) tick();
    checks++; if (cnt1 !== 5'd0) begin errors++; $display("FAIL flush_early: got %0d exp 0", cnt1); end
    tick();
    checks++; if (cnt1 !== 5'd1) begin errors++; $display("FAIL flush_count: got %0d exp 1", cnt1); end
    checks++; if (bus1.OutData !== 32'h000011AA) begin errors++; $display("FAIL flush_data: got %h exp 000011aa", bus1.OutData); end
    checks++; if (bus1.OutLanes !== 2'b01) begin errors++; $display("FAIL flush_lanes: got %b exp 01", bus1.OutLanes); end
    checks++; if (bus1.OutX !== 16'd6 || bus1.OutY !== 16'd2) begin errors++; $display("FAIL flush_xy: got %0d,%0d exp 6,2", bus1.OutX, bus1.OutY); end
    bus1.OutReady = 1'b1;
    tick();
    bus1.OutReady = 1'b0;
  endtask

  task automatic test_break();
    drive1(16'd2, 16'd1, 8'hF8, 8'h00, 8'h00);
    tick();
    drive1(16'd5, 16'd1, 8'h00, 8'hFC, 8'h00);
    tick();
    drive1(16'd6, 16'd1, 8'h00, 8'h00, 8'hF8);
    tick();
    bus1.InEnable = 1'b0;
    checks++; if (cnt1 !== 5'd2) begin errors++; $display("FAIL break_count: got %0d exp 2", cnt1); end
    checks++; if (bus1.OutData !== 32'h0000F800 || bus1.OutLanes !== 2'b01 || bus1.OutX !== 16'd2) begin
      errors++; $display("FAIL break_head: got %h/%b/%0d exp 0000f800/01/2", bus1.OutData, bus1.OutLanes, bus1.OutX); end
    bus1.OutReady = 1'b1;
    tick();
    checks++; if (bus1.OutData !== 32'h001F07E0 || bus1.OutLanes !== 2'b11 || bus1.OutX !== 16'd5) begin
      errors++; $display("FAIL break_pair: got %h/%b/%0d exp 001f07e0/11/5", bus1.OutData, bus1.OutLanes, bus1.OutX); end
    tick();
    bus1.OutReady = 1'b0;
    checks++; if (cnt1 !== 5'd0) begin errors++; $display("FAIL break_drain: got %0d exp 0", cnt1); end
  endtask

  task automatic test_last_clip();
    logic [4:0] expClip;
`ifdef AQ_DJPEG_PIXOUT_CLIP_EN
    expClip = 5'd0;
`else
    expClip = 5'd1;
`endif
    drive0(16'd12, 16'd0, 8'h01, 8'h02, 8'h03);
    tick();
    bus0.InEnable = 1'b0;
    checks++; if (cnt0 !== expClip) begin errors++; $display("FAIL clip_count: got %0d exp %0d", cnt0, expClip); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL clip_ovf: got %b exp 0", ovf0); end
    bus0.OutReady = 1'b1;
    tick();
    bus0.OutReady = 1'b0;
    drive0(16'd9, 16'd7, 8'h01, 8'h02, 8'h03);
    tick();
    bus0.InEnable = 1'b0;
    checks++; if (cnt0 !== 5'd1 || bus0.OutLast !== 1'b1) begin errors++; $display("FAIL last888: got cnt %0d last %b exp 1/1", cnt0, bus0.OutLast); end
    bus0.OutReady = 1'b1;
    tick();
    bus0.OutReady = 1'b0;
    drive1(16'd9, 16'd7, 8'hFF, 8'h00, 8'h00);
    tick();
    bus1.InEnable = 1'b0;
    checks++; if (cnt1 !== 5'd1 || bus1.OutLast !== 1'b1 || bus1.OutLanes !== 2'b01 || bus1.OutX !== 16'd9) begin
      errors++; $display("FAIL last565_single: got cnt %0d last %b lanes %b x %0d exp 1/1/01/9", cnt1, bus1.OutLast, bus1.OutLanes, bus1.OutX); end
    bus1.OutReady = 1'b1;
    tick();
    bus1.OutReady = 1'b0;
    drive1(16'd8, 16'd7, 8'h00, 8'hFF, 8'h00);
    tick();
    drive1(16'd9, 16'd7, 8'h00, 8'h00, 8'hFF);
    tick();
    bus1.InEnable = 1'b0;
    checks++; if (cnt1 !== 5'd1 || bus1.OutLast !== 1'b1 || bus1.OutLanes !== 2'b11 || bus1.OutX !== 16'd8) begin
      errors++; $display("FAIL last565_pair: got cnt %0d last %b lanes %b x %0d exp 1/1/11/8", cnt1, bus1.OutLast, bus1.OutLanes, bus1.OutX); end
    checks++; if (bus1.OutData !== 32'h001F07E0) begin errors++; $display("FAIL last565_data: got %h exp 001f07e0", bus1.OutData); end
    bus1.OutReady = 1'b1;
    tick();
    bus1.OutReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bus0.OutReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive0(16'(i), 16'd4, 8'(i * 16), 8'h55, 8'hAA);
      tick();
      e = {8'h00, 8'(i * 16), 8'h55, 8'hAA};
      checks++; if (bus0.OutData !== e || cnt0 !== 5'd1) begin
        errors++; $display("FAIL b2b_%0d: got %h cnt %0d exp %h cnt 1", i, bus0.OutData, cnt0, e); end
    end
    bus0.InEnable = 1'b0;
    tick();
    bus0.OutReady = 1'b0;
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL b2b_drain: got %0d exp 0", cnt0); end
  endtask

  task automatic test_full_overflow();
    logic [4:0] expC;
    for (int k = 1; k <= 20; k++) begin
      drive0(16'((k - 1) % 8), 16'((k - 1) / 8), 8'(k - 1), 8'hA0, 8'(k));
      tick();
      expC = (k > 16) ? 5'd16 : 5'(k);
      checks++; if (cnt0 !== expC) begin errors++; $display("FAIL full_count_%0d: got %0d exp %0d", k, cnt0, expC); end
      checks++; if (bus0.InFull !== (k >= 13)) begin errors++; $display("FAIL full_infull_%0d: got %b exp %b", k, bus0.InFull, (k >= 13)); end
      checks++; if (ovf0 !== (k >= 17)) begin errors++; $display("FAIL full_ovf_%0d: got %b exp %b", k, ovf0, (k >= 17)); end
    end
    bus0.InEnable = 1'b0;
    checks++; if (bus0.OutData !== 32'h0000A001) begin errors++; $display("FAIL full_head: got %h exp 0000a001", bus0.OutData); end
    bus0.OutReady = 1'b1;
    drive0(16'd4, 16'd2, 8'd20, 8'hA0, 8'd21);
    tick();
    bus0.InEnable = 1'b0;
    bus0.OutReady = 1'b0;
    checks++; if (cnt0 !== 5'd16 || bus0.OutData !== 32'h0001A002) begin
      errors++; $display("FAIL full_push_pop: got cnt %0d head %h exp 16/0001a002", cnt0, bus0.OutData); end
    Init = 1'b1;
    drive0(16'd1, 16'd1, 8'h11, 8'h22, 8'h33);
    tick();
    Init = 1'b0;
    bus0.InEnable = 1'b0;
    checks++; if (cnt0 !== 5'd0 || bus0.OutValid !== 1'b0) begin errors++; $display("FAIL init_count: got %0d/%b exp 0/0", cnt0, bus0.OutValid); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL init_ovf: got %b exp 0", ovf0); end
    checks++; if (bus0.InFull !== 1'b0) begin errors++; $display("FAIL init_infull: got %b exp 0", bus0.InFull); end
    tick();
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL init_ignored_pixel: got %0d exp 0", cnt0); end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 5; k++) begin
      drive0(16'(k), 16'd3, 8'(k), 8'h11, 8'h22);
      tick();
    end
    bus0.InEnable = 1'b0;
    drive1(16'd2, 16'd2, 8'h40, 8'h40, 8'h40);
    tick();
    bus1.InEnable = 1'b0;
    checks++; if (cnt0 !== 5'd5) begin errors++; $display("FAIL mid_count: got %0d exp 5", cnt0); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cnt0 !== 5'd0 || bus0.OutValid !== 1'b0) begin errors++; $display("FAIL mid_async_count: got %0d/%b exp 0/0", cnt0, bus0.OutValid); end
    checks++; if (bus0.OutData !== 32'h0 || bus0.OutX !== 16'h0 || bus0.OutY !== 16'h0 || bus0.OutLanes !== 2'b00) begin
      errors++; $display("FAIL mid_async_outputs: got %h %0d %0d %b exp zeros", bus0.OutData, bus0.OutX, bus0.OutY, bus0.OutLanes); end
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    checks++; if (cnt0 !== 5'd0 || cnt1 !== 5'd0) begin errors++; $display("FAIL mid_stale: got %0d/%0d exp 0/0", cnt0, cnt1); end
    drive0(16'd1, 16'd1, 8'hAB, 8'hCD, 8'hEF);
    tick();
    bus0.InEnable = 1'b0;
    checks++; if (cnt0 !== 5'd1 || bus0.OutData !== 32'h00ABCDEF) begin
      errors++; $display("FAIL mid_resume: got cnt %0d data %h exp 1/00abcdef", cnt0, bus0.OutData); end
    bus0.OutReady = 1'b1;
    tick();
    bus0.OutReady = 1'b0;
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL mid_drain: got %0d exp 0", cnt0); end
  endtask

  initial begin
    test_reset();
    test_rgb888();
    test_pack_pair();
    test_flush();
    test_break();
    test_last_clip();
    test_back_to_back();
    test_full_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_pixout.md
AQ_DJPEG_PIXOUT -- requirements
Module: aq_djpeg_pixout

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 4.
REQ-002 Parameter AFULL_LEVEL, default 12, occupancy at which InFull asserts; must satisfy 1 <= AFULL_LEVEL <= DEPTH.
REQ-003 Parameter PIX_FMT, default 0, selects the pixel format: 0 = RGB888, 1 = RGB565 with two pixels packed per word.
REQ-004 Parameter FLUSH_CYC, default 4, number of idle cycles before a held RGB565 half-word is flushed.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 Init  in  1  decoder idle (JpegDecodeIdle), synchronous clear while high.
REQ-008 InEnable  in  1  pixel strobe from the colour converter.
REQ-009 InPixelX, InPixelY  in  16 each  pixel coordinates.
REQ-010 InR, InG, InB  in  8 each  pixel colour.
REQ-011 InWidth, InHeight  in  16 each  image size from the header FSM.
REQ-012 InFull  out  1  backpressure to the decoder (DataInFull).
REQ-013 OutValid  out  1  output word available.
REQ-014 OutReady  in  1  sink accepts the word.
REQ-015 OutData  out  32  packed pixel data.
REQ-016 OutX, OutY  out  16 each  coordinates of lane 0.
REQ-017 OutLanes  out  2  valid pixel lanes: 01 = lane 0 only, 11 = both lanes.
REQ-018 OutLast  out  1  word contains pixel (InWidth-1, InHeight-1).
REQ-019 Overflow  out  1  sticky flag: a pixel was dropped.
REQ-020 Count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-021 The FIFO SHALL be show-ahead; each entry holds {data, X, Y, lanes, last}. OutValid SHALL equal Count != 0.
REQ-022 A pop SHALL occur on OutValid & OutReady; the entry outputs SHALL remain stable while OutValid & !OutReady.
REQ-023 At most one push SHALL occur per cycle; a push SHALL be accepted when Count < DEPTH, or when Count == DEPTH and a pop occurs in the same cycle.
REQ-024 A push that is not accepted SHALL drop its pixel or word and set Overflow; Overflow SHALL be cleared only by rst or Init.
REQ-025 InFull SHALL be registered and equal (Count >= AFULL_LEVEL) evaluated on the previous cycle.
REQ-026 PIX_FMT=0: each accepted pixel SHALL be pushed as OutData = {8'h00, R, G, B}, OutLanes = 01, with OutValid asserted in cycle N+1 for an input at cycle N when the FIFO was empty.
REQ-027 PIX_FMT=1: the packer SHALL have two states, EMPTY and HALF; the RGB565 value SHALL be {R[7:3], G[7:2], B[7:3]}, lane 0 = OutData[15:0], lane 1 = OutData[31:16].
REQ-028 EMPTY + InEnable: store the pixel, go to HALF, no push; if the pixel is the last pixel, push it immediately with lanes 01 instead and stay in EMPTY.
REQ-029 HALF + InEnable with the same Y and X == held X + 1: push with lanes 11, go to EMPTY.
REQ-030 HALF + InEnable otherwise: push the held pixel with lanes 01, store the new pixel, stay in HALF.
REQ-031 HALF + no InEnable for FLUSH_CYC consecutive cycles: push the held pixel with lanes 01, go to EMPTY; the idle counter SHALL reset on every InEnable.
REQ-032 OutLast SHALL be set on an entry whose lane 0 or lane 1 pixel equals (InWidth-1, InHeight-1).
REQ-033 Init high SHALL empty the FIFO, return the packer to EMPTY, clear Overflow, the idle counter and InFull, and ignore InEnable.

Reset
REQ-034 While rst is low: Count = 0, OutValid = 0, InFull = 0, Overflow = 0, OutData/OutX/OutY/OutLanes/OutLast = 0, packer = EMPTY, idle counter = 0.
REQ-035 Reset mid-frame SHALL discard all stored pixels; operation SHALL resume on the first clk edge after rst rises.

Configuration
REQ-036 Macro AQ_DJPEG_PIXOUT_CLIP_EN defined: pixels with X >= InWidth or Y >= InHeight (MCU padding) SHALL be discarded before the packer, without setting Overflow.
REQ-037 Macro AQ_DJPEG_PIXOUT_CLIP_EN undefined: all pixels SHALL pass; OutLast SHALL still be computed as in REQ-032.

Verification
REQ-038 PIX_FMT=0, OutReady=1, pixel (3,5) RGB=(0x12,0x34,0x56) -> next cycle OutValid=1, OutData=0x00123456, OutX=3, OutY=5, OutLanes=01.
REQ-039 PIX_FMT=1, pixels (0,0) RGB=FF/FF/FF then (1,0) RGB=00/00/00 on consecutive cycles -> one word 0x0000FFFF, lanes 11.
REQ-040 PIX_FMT=1, single pixel (6,2) followed by 4 idle cycles -> one word with lanes 01, OutX=6.
REQ-041 DEPTH=16, OutReady=0, 20 pixels (PIX_FMT=0) -> Count=16, InFull high from the cycle after Count reaches 12, Overflow=1, 4 pixels lost; then Init pulse -> Count=0, Overflow=0.
REQ-042 CLIP_EN, InWidth=10, pixel (12,0) -> no push; pixel (9,7) with InHeight=8 -> OutLast=1.
REQ-043 rst asserted low while Count=5 -> all outputs 0 asynchronously; no stale words after release.
